// File: rtl/icache_tag_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_ctrl_if
//  Brief    : Fetch request/response and line-refill handshake bundle.
//  Revision : 1.0
// ============================================================================
interface icache_tag_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_miss;
    logic              refill_req;
    logic [ADDR_W-1:0] refill_addr;
    logic              refill_done;

    // master is the fetch/refill side, slave is the tag controller
    modport master (
        output req_valid, req_addr, refill_done,
        input  req_ready, rsp_valid, rsp_miss, refill_req, refill_addr
    );

    modport slave (
        input  req_valid, req_addr, refill_done,
        output req_ready, rsp_valid, rsp_miss, refill_req, refill_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_ctrl
//  Brief    : Direct-mapped I-cache tag lookup, refill and invalidate sweep.
//  Revision : 1.0
// ============================================================================
module icache_tag_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  wire                                  clk,
    input  wire                                  rst,
    icache_tag_ctrl_if.slave                     bus,
    input  wire                                  flush,
    output logic [INDEX_W-1:0]                   tag_rd_addr,
    input  wire  [ADDR_W-INDEX_W-OFFSET_W:0]     tag_rd_data,
    output logic [INDEX_W-1:0]                   tag_wr_addr,
    output logic [ADDR_W-INDEX_W-OFFSET_W:0]     tag_wr_data,
    output logic                                 tag_wr_en,
    output logic                                 init_busy
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_REFILL = 3'd3,
        S_UPDATE = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t              state_q,       state_d;
    logic [INDEX_W-1:0]  cnt_q,         cnt_d;
    logic [TAG_W-1:0]    tag_q,         tag_d;
    logic [INDEX_W-1:0]  idx_q,         idx_d;
    logic                miss_q,        miss_d;
    logic                flush_pend_q,  flush_pend_d;
    logic                refill_req_q,  refill_req_d;
    logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;

    logic [TAG_W-1:0]    w_req_tag;
    logic [INDEX_W-1:0]  w_req_idx;
    logic                w_hit;
    logic                w_req_ready;
    logic                w_wr_en;

    assign w_req_tag = bus.req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_req_idx = bus.req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_hit     = tag_rd_data[TAG_W] && (tag_rd_data[TAG_W-1:0] == tag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            tag_q         <= '0;
            idx_q         <= '0;
            miss_q        <= 1'b0;
            flush_pend_q  <= 1'b0;
            refill_req_q  <= 1'b0;
            refill_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            idx_q         <= idx_d;
            miss_q        <= miss_d;
            flush_pend_q  <= flush_pend_d;
            refill_req_q  <= refill_req_d;
            refill_addr_q <= refill_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        miss_d        = miss_q;
        flush_pend_d  = flush_pend_q;
        refill_req_d  = refill_req_q;
        refill_addr_d = refill_addr_q;
        w_req_ready   = 1'b0;
        w_wr_en       = 1'b0;
        tag_rd_addr   = idx_q;
        tag_wr_addr   = idx_q;
        tag_wr_data   = '0;

        case (state_q)
            S_INIT: begin
                w_wr_en     = 1'b1;
                tag_wr_addr = cnt_q;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == {INDEX_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // RAM samples the live index on the accept edge
                tag_rd_addr = w_req_idx;
                if (flush || flush_pend_q) begin
                    state_d      = S_INIT;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    w_req_ready = 1'b1;
                    if (bus.req_valid) begin
                        tag_d   = w_req_tag;
                        idx_d   = w_req_idx;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    miss_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    refill_req_d  = 1'b1;
                    refill_addr_d = {tag_q, idx_q, {OFFSET_W{1'b0}}};
                    state_d       = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.refill_done) begin
                    refill_req_d = 1'b0;
                    state_d      = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_wr_en     = 1'b1;
                tag_wr_data = {1'b1, tag_q};
                miss_d      = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        // A sweep in progress already covers any flush that arrives during it
        if (flush && (state_q inside {S_LOOKUP, S_REFILL, S_UPDATE, S_RESP})) begin
            flush_pend_d = 1'b1;
        end
    end

    assign tag_wr_en       = w_wr_en && !rst;
    assign init_busy       = (state_q == S_INIT);
    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_miss    = miss_q;
    assign bus.refill_req  = refill_req_q;
    assign bus.refill_addr = refill_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_tag_ctrl
//  Brief    : Directed self-checking bench for icache_tag_ctrl with tag RAM model.
//  Revision : 1.0
// ============================================================================
module tb_icache_tag_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [7:0]  tag_rd_addr;
    logic [20:0] tag_rd_data;
    logic [7:0]  tag_wr_addr;
    logic [20:0] tag_wr_data;
    logic        tag_wr_en;
    logic        init_busy;

    int errors = 0;
    int checks = 0;

    icache_tag_ctrl_if #(.ADDR_W(32)) bus ();

    icache_tag_ctrl #(
        .ADDR_W   (32),
        .INDEX_W  (8),
        .OFFSET_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
        .tag_rd_addr (tag_rd_addr),
        .tag_rd_data (tag_rd_data),
        .tag_wr_addr (tag_wr_addr),
        .tag_wr_data (tag_wr_data),
        .tag_wr_en   (tag_wr_en),
        .init_busy   (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256x21 simple-dual-port tag RAM, one-cycle read latency
    logic [20:0] tag_mem [256];
    always @(posedge clk) begin
        if (tag_wr_en) tag_mem[tag_wr_addr] <= tag_wr_data;
        tag_rd_data <= tag_mem[tag_rd_addr];
    end

    int sweep_cnt = 0;
    int sweep_bad = 0;
    int ready_bad = 0;
    int sw_idx    = 0;
    always @(posedge clk) begin
        if (!init_busy) sw_idx = 0;
        if (tag_wr_en && init_busy) begin
            if (tag_wr_addr != sw_idx[7:0] || tag_wr_data != 21'd0) sweep_bad++;
            sweep_cnt++;
            sw_idx++;
        end
        if (init_busy && bus.req_ready) ready_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr);
        int n = 0;
        while (!bus.req_ready && n < 400) begin
            tick();
            n++;
        end
        check("issue_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_sweep(input int exp_cycles, input bit spurious_done);
        int n  = 0;
        int s0 = sweep_cnt;
        int b0 = sweep_bad;
        int r0 = ready_bad;
        if (spurious_done) bus.refill_done = 1'b1;
        do begin
            tick();
            bus.refill_done = 1'b0;
            n++;
        end while (init_busy && n < 400);
        check("sweep_cycles", n, exp_cycles);
        check("sweep_writes", sweep_cnt - s0, 256);
        check("sweep_addr_data", sweep_bad - b0, 0);
        check("sweep_ready_low", ready_bad - r0, 0);
        check("sweep_end_ready", bus.req_ready, 1);
        check("sweep_end_refill", bus.refill_req, 0);
    endtask

    task automatic expect_hit(input logic [31:0] addr);
        issue(addr);
        tick();
        check("hit_rsp_valid", bus.rsp_valid, 1);
        check("hit_rsp_miss", bus.rsp_miss, 0);
        check("hit_no_refill", bus.refill_req, 0);
        tick();
        check("hit_rsp_pulse", bus.rsp_valid, 0);
    endtask

    task automatic expect_miss(input logic [31:0] addr, input logic [31:0] exp_raddr,
                               input logic [7:0] exp_idx, input logic [20:0] exp_data,
                               input bit do_flush);
        issue(addr);
        tick();
        check("miss_refill_req", bus.refill_req, 1);
        check("miss_refill_addr", bus.refill_addr, exp_raddr);
        check("miss_rsp_idle", bus.rsp_valid, 0);
        if (do_flush) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            repeat (3) tick();
        end else begin
            repeat (4) tick();
        end
        check("miss_refill_held", bus.refill_req, 1);
        check("miss_refill_addr_held", bus.refill_addr, exp_raddr);
        bus.refill_done = 1'b1;
        tick();
        bus.refill_done = 1'b0;
        check("upd_wr_en", tag_wr_en, 1);
        check("upd_wr_addr", tag_wr_addr, exp_idx);
        check("upd_wr_data", tag_wr_data, exp_data);
        check("upd_refill_drop", bus.refill_req, 0);
        check("upd_rsp_idle", bus.rsp_valid, 0);
        tick();
        check("miss_rsp_valid", bus.rsp_valid, 1);
        check("miss_rsp_miss", bus.rsp_miss, 1);
        check("miss_wr_idle", tag_wr_en, 0);
        tick();
        check("miss_rsp_pulse", bus.rsp_valid, 0);
        check("post_rsp_ready", bus.req_ready, !do_flush);
        check("post_rsp_busy", init_busy, 0);
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = 32'h0;
        bus.refill_done = 1'b0;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_init_busy", init_busy, 1);
        check("rst_wr_en", tag_wr_en, 0);
        check("rst_refill_req", bus.refill_req, 0);
        check("rst_refill_addr", bus.refill_addr, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_miss", bus.rsp_miss, 0);
        rst = 1'b0;
        wait_sweep(256, 1'b0);

        // cold miss, then hit on same line
        expect_miss(32'h0000_1230, 32'h0000_1230, 8'h23, 21'h100001, 1'b0);
        expect_hit(32'h0000_123C);

        // conflicting tag on index 0x23 evicts, then original misses again
        expect_miss(32'h0010_1230, 32'h0010_1230, 8'h23, 21'h100101, 1'b0);
        expect_miss(32'h0000_1230, 32'h0000_1230, 8'h23, 21'h100001, 1'b0);
        expect_hit(32'h0000_1238);

        // flush during refill: request completes, then full sweep
        expect_miss(32'h0010_1230, 32'h0010_1230, 8'h23, 21'h100101, 1'b1);
        wait_sweep(257, 1'b0);
        expect_miss(32'h0010_1230, 32'h0010_1230, 8'h23, 21'h100101, 1'b0);

        // reset two cycles into refill abandons it
        issue(32'h0000_1230);
        tick();
        check("rr_refill_req", bus.refill_req, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rr_refill_drop", bus.refill_req, 0);
        check("rr_init_busy", init_busy, 1);
        check("rr_wr_gated", tag_wr_en, 0);
        check("rr_rsp_valid", bus.rsp_valid, 0);
        rst = 1'b0;
        wait_sweep(256, 1'b1);
        expect_miss(32'h0000_1230, 32'h0000_1230, 8'h23, 21'h100001, 1'b0);
        expect_hit(32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
- Lookup and refill controller for the instruction-cache tag store. It sits directly upstream of the 256x21 simple-dual-port tag RAM, driving its read and write ports and consuming its read data.
- Direct-mapped organisation: it splits a fetch address into tag, index and offset, then compares the tag against the stored entry.
- On a miss it handshakes a line refill, then writes the new tag.
- It also performs the invalidate sweep after reset and on flush.

Parameters:
- ADDR_W, 32, fetch address width.
- INDEX_W, 8, set index width; must equal the tag RAM address width.
- OFFSET_W, 4, line offset width (16-byte lines).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (20), derived localparam. Tag RAM entry width is TAG_W+1: {valid, tag}.

Ports:
- clk  in  1  single clock; also drives tag RAM wr_clk and rd_clk
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch lookup request
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_W  fetch address
- rsp_valid  out  1  one-cycle pulse: line for the accepted request is resident
- rsp_miss  out  1  qualifies rsp_valid: 1 = request required a refill
- flush  in  1  invalidate all entries
- refill_req  out  1  line refill request; level, held until done
- refill_addr  out  ADDR_W  line-aligned refill address (offset bits zero)
- refill_done  in  1  one-cycle pulse: data array line written
- tag_rd_addr  out  INDEX_W  to tag RAM rd_addr
- tag_rd_data  in  TAG_W+1  from tag RAM rd_data (1-cycle read latency, no output register)
- tag_wr_addr  out  INDEX_W  to tag RAM wr_addr
- tag_wr_data  out  TAG_W+1  to tag RAM wr_data
- tag_wr_en  out  1  to tag RAM wr_en
- init_busy  out  1  invalidate sweep in progress

Behaviour:
- Address split: tag = req_addr[ADDR_W-1:INDEX_W+OFFSET_W], index = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W].
- States: INIT, IDLE, LOOKUP, REFILL, UPDATE, RESP.
- Reset:
  - State goes to INIT with sweep counter 0.
  - req_ready=0, rsp_valid=0, rsp_miss=0, refill_req=0, refill_addr=0, tag_wr_en=0, init_busy=1.
  - Any pending flush is cleared.
- INIT:
  - Each cycle: tag_wr_en=1, tag_wr_addr=counter, tag_wr_data=0; counter increments.
  - After writing index 2^INDEX_W-1, go to IDLE.
  - Exactly 256 write cycles; init_busy is high throughout and low from IDLE onward.
- IDLE:
  - req_ready=1 unless a flush is pending or flush is high.
  - tag_rd_addr = index of req_addr, combinational, so the RAM samples on the accept edge.
  - On req_valid&&req_ready: register address, go to LOOKUP.
  - flush in IDLE: go to INIT next cycle, with req_ready=0 that cycle. Flush has priority over req_valid.
- LOOKUP:
  - tag_rd_addr is held at the registered index.
  - Hit = tag_rd_data[TAG_W] && tag_rd_data[TAG_W-1:0]==registered tag.
  - Hit: go to RESP with rsp_miss=0. Miss: go to REFILL.
- REFILL:
  - refill_req=1 and refill_addr={registered tag, index, OFFSET_W zeros}, both registered and stable until refill_done.
  - On refill_done: refill_req drops next cycle, go to UPDATE.
- UPDATE:
  - Single cycle: tag_wr_en=1, tag_wr_addr=index, tag_wr_data={1'b1, tag}.
  - Go to RESP with rsp_miss=1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE. No backpressure on the response.
- Latency from accept edge: hit response at cycle +2; miss response 2 cycles after the refill_done cycle.
- flush outside IDLE/INIT: latched as pending and executed on the next IDLE cycle, before any new accept. The in-flight request still completes and its tag is written, then wiped by the sweep.
- flush during INIT: ignored; the sweep already invalidates everything.
- refill_done outside REFILL: ignored.
- req_valid outside IDLE: ignored; req_ready=0.
- rst mid-refill: refill_req drops on the next cycle and the controller restarts INIT. The refill source must tolerate an abandoned request.
- tag_wr_en is asserted only in INIT and UPDATE. No same-address read/write collision can occur, because LOOKUP never overlaps UPDATE.

Test Plan:
- Reset then idle:
  - tag_wr_en high exactly 256 cycles, addresses 0..255, data 0.
  - init_busy falls and req_ready rises the cycle after index 255 is written.
- Cold miss on req_addr=0x0000_1230:
  - refill_req=1 with refill_addr=0x0000_1230.
  - Driving refill_done 5 cycles later gives tag_wr_en with addr 0x23, data {1,0x00001}.
  - rsp_valid with rsp_miss=1 follows 2 cycles after refill_done.
- Repeat 0x0000_123C after that refill:
  - Hit: rsp_valid at accept+2, rsp_miss=0, no refill_req.
- Conflict 0x0010_1230 (same index 0x23, tag 0x00101):
  - Miss, refill_addr=0x0010_1230, entry overwritten with {1,0x00101}.
  - A subsequent 0x0000_1230 misses again.
- flush asserted while in REFILL:
  - The request completes with rsp_miss=1, then a 256-cycle sweep with req_ready=0.
  - The next access to 0x0010_1230 misses.
- rst asserted 2 cycles into REFILL:
  - refill_req=0 the next cycle, a full sweep runs, and a spurious refill_done during INIT has no effect.
